// File: rtl/priv_1_12_trap_sequencer_if.sv
// priv_1_12_trap_sequencer_if: pipeline/CSR-file side signals of the M-mode trap sequencer
interface priv_1_12_trap_sequencer_if;
    logic        ex_valid;
    logic [3:0]  ex_cause;
    logic [31:0] ex_epc;
    logic [31:0] ex_tval;
    logic [2:0]  irq_pend;
    logic [2:0]  irq_en;
    logic        mstatus_mie;
    logic [31:0] irq_epc;
    logic        mret_req;
    logic [31:0] mepc_in;
    logic [29:0] mtvec_base;
    logic        mtvec_mode;
    logic        pipe_quiesced;
    logic        redirect_ack;
    logic        flush;
    logic        csr_we;
    logic [31:0] mepc_out;
    logic [31:0] mcause_out;
    logic [31:0] mtval_out;
    logic        mstatus_push;
    logic        mstatus_pop;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        drain_timeout;
    logic        busy;
    modport slave (
        input  ex_valid, ex_cause, ex_epc, ex_tval, irq_pend, irq_en, mstatus_mie, irq_epc,
               mret_req, mepc_in, mtvec_base, mtvec_mode, pipe_quiesced, redirect_ack,
        output flush, csr_we, mepc_out, mcause_out, mtval_out, mstatus_push, mstatus_pop,
               redirect_valid, redirect_pc, drain_timeout, busy
    );
    modport master (
        output ex_valid, ex_cause, ex_epc, ex_tval, irq_pend, irq_en, mstatus_mie, irq_epc,
               mret_req, mepc_in, mtvec_base, mtvec_mode, pipe_quiesced, redirect_ack,
        input  flush, csr_we, mepc_out, mcause_out, mtval_out, mstatus_push, mstatus_pop,
               redirect_valid, redirect_pc, drain_timeout, busy
    );
endinterface

// File: rtl/priv_1_12_trap_sequencer.sv
// priv_1_12_trap_sequencer: orders M-mode traps/MRET and sequences drain, CSR save, mstatus update, redirect
module priv_1_12_trap_sequencer #(
    parameter bit VECTORED_EN = 1'b1,
    parameter int DRAIN_MAX   = 15
) (
    input logic CLK,
    input logic RST,
    priv_1_12_trap_sequencer_if.slave bus
);
    localparam int CW = (DRAIN_MAX < 1) ? 1 : $clog2(DRAIN_MAX + 1);
    typedef enum logic [2:0] {IDLE, DRAIN, SAVE, PUSH, POP, REDIR} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   mepc_q, mcause_q, mtval_q, tgt_q, rpc_q;
    logic          csr_we_q, push_q, pop_q, rv_q;
    logic [2:0]    hit;
    logic [3:0]    irq_code;
    logic [31:0]   base, vec_pc;
    logic          irq, take, cnt_max;
    assign hit      = bus.irq_pend & bus.irq_en & {3{bus.mstatus_mie}};
    assign irq      = |hit;
    assign take     = bus.ex_valid | irq;
    assign irq_code = hit[2] ? 4'd11 : hit[0] ? 4'd3 : 4'd7;
    assign base     = {bus.mtvec_base, 2'b00};
    assign vec_pc   = base + {26'd0, irq_code, 2'b00};
    assign cnt_max  = cnt == CW'(DRAIN_MAX);
    assign bus.flush          = ~RST & (state == IDLE) & take;
    assign bus.drain_timeout  = (state == DRAIN) & ~bus.pipe_quiesced & cnt_max;
    assign bus.busy           = state != IDLE;
    assign bus.csr_we         = csr_we_q;
    assign bus.mepc_out       = mepc_q;
    assign bus.mcause_out     = mcause_q;
    assign bus.mtval_out      = mtval_q;
    assign bus.mstatus_push   = push_q;
    assign bus.mstatus_pop    = pop_q;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = rpc_q;
    // trap/return sequencer; strobes are set on entry to their state so they last one cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
            tgt_q    <= '0;
            rpc_q    <= '0;
            csr_we_q <= 1'b0;
            push_q   <= 1'b0;
            pop_q    <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            csr_we_q <= 1'b0;
            push_q   <= 1'b0;
            pop_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        state    <= DRAIN;
                        mepc_q   <= bus.ex_valid ? bus.ex_epc : bus.irq_epc;
                        mtval_q  <= bus.ex_valid ? bus.ex_tval : 32'd0;
                        mcause_q <= bus.ex_valid ? {28'd0, bus.ex_cause} : {1'b1, 27'd0, irq_code};
                        tgt_q    <= (!bus.ex_valid && VECTORED_EN && bus.mtvec_mode) ? vec_pc : base;
                    end else if (bus.mret_req) begin
                        state <= POP;
                        pop_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.pipe_quiesced || cnt_max) begin
                        state    <= SAVE;
                        cnt      <= '0;
                        csr_we_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SAVE: begin
                    state  <= PUSH;
                    push_q <= 1'b1;
                end
                PUSH: begin
                    state <= REDIR;
                    rv_q  <= 1'b1;
                    rpc_q <= tgt_q;
                end
                POP: begin
                    state <= REDIR;
                    rv_q  <= 1'b1;
                    rpc_q <= bus.mepc_in;
                end
                REDIR: begin
                    if (bus.redirect_ack) begin
                        state <= IDLE;
                        rv_q  <= 1'b0;
                        rpc_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_priv_1_12_trap_sequencer.sv
// tb_priv_1_12_trap_sequencer: directed checks of trap ordering, sequencing latency, timeout and reset abort
module tb_priv_1_12_trap_sequencer;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;
    priv_1_12_trap_sequencer_if bus ();
    priv_1_12_trap_sequencer #(.VECTORED_EN(1'b1), .DRAIN_MAX(15)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    // free-running clock
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge CLK);
        #1;
    endtask
    task automatic quiet;
        bus.ex_valid     = 1'b0;
        bus.mret_req     = 1'b0;
        bus.irq_pend     = 3'b000;
        bus.redirect_ack = 1'b0;
    endtask
    task automatic outputs_zero(input string t);
        check({t, ":flush"}, bus.flush, 0);
        check({t, ":csr_we"}, bus.csr_we, 0);
        check({t, ":mepc"}, bus.mepc_out, 0);
        check({t, ":mcause"}, bus.mcause_out, 0);
        check({t, ":mtval"}, bus.mtval_out, 0);
        check({t, ":push"}, bus.mstatus_push, 0);
        check({t, ":pop"}, bus.mstatus_pop, 0);
        check({t, ":rv"}, bus.redirect_valid, 0);
        check({t, ":rpc"}, bus.redirect_pc, 0);
        check({t, ":dto"}, bus.drain_timeout, 0);
        check({t, ":busy"}, bus.busy, 0);
    endtask
    // trap event already driven in cycle 0; walks cycles 0..5 with pipe_quiesced=1
    task automatic seq(input string t, input logic [31:0] cause, input logic [31:0] epc,
                       input logic [31:0] tval, input logic [31:0] pc);
        #1 check({t, ":flush@0"}, bus.flush, 1);
        step;
        quiet;
        check({t, ":busy@1"}, bus.busy, 1);
        check({t, ":flush@1"}, bus.flush, 0);
        check({t, ":pop@1"}, bus.mstatus_pop, 0);
        check({t, ":csr_we@1"}, bus.csr_we, 0);
        step;
        check({t, ":csr_we@2"}, bus.csr_we, 1);
        check({t, ":mcause@2"}, bus.mcause_out, cause);
        check({t, ":mepc@2"}, bus.mepc_out, epc);
        check({t, ":mtval@2"}, bus.mtval_out, tval);
        check({t, ":push@2"}, bus.mstatus_push, 0);
        step;
        check({t, ":push@3"}, bus.mstatus_push, 1);
        check({t, ":csr_we@3"}, bus.csr_we, 0);
        check({t, ":rv@3"}, bus.redirect_valid, 0);
        step;
        check({t, ":rv@4"}, bus.redirect_valid, 1);
        check({t, ":rpc@4"}, bus.redirect_pc, pc);
        check({t, ":push@4"}, bus.mstatus_push, 0);
        bus.redirect_ack = 1'b1;
        step;
        bus.redirect_ack = 1'b0;
        check({t, ":rv@5"}, bus.redirect_valid, 0);
        check({t, ":busy@5"}, bus.busy, 0);
    endtask
    initial begin
        quiet;
        bus.ex_cause      = 4'd0;
        bus.ex_epc        = '0;
        bus.ex_tval       = '0;
        bus.irq_en        = 3'b000;
        bus.mstatus_mie   = 1'b0;
        bus.irq_epc       = '0;
        bus.mepc_in       = '0;
        bus.mtvec_base    = 30'h10;
        bus.mtvec_mode    = 1'b0;
        bus.pipe_quiesced = 1'b1;
        #12;
        bus.ex_valid = 1'b1;
        #1 outputs_zero("reset");
        @(posedge CLK);
        #1 RST = 1'b0;
        quiet;
        step;
        // plain exception, DIRECT target
        bus.ex_valid = 1'b1;
        bus.ex_cause = 4'd2;
        bus.ex_epc   = 32'h100;
        bus.ex_tval  = 32'hDEAD;
        seq("exc", 32'h2, 32'h100, 32'hDEAD, 32'h40);
        // all interrupts pending, vectored: MEI wins
        bus.mtvec_mode  = 1'b1;
        bus.irq_pend    = 3'b111;
        bus.irq_en      = 3'b111;
        bus.mstatus_mie = 1'b1;
        bus.irq_epc     = 32'h300;
        seq("mei", 32'h8000000B, 32'h300, 32'h0, 32'h6C);
        // global enable off: nothing taken
        bus.irq_pend    = 3'b111;
        bus.mstatus_mie = 1'b0;
        #1 check("mie0:flush", bus.flush, 0);
        step;
        check("mie0:busy1", bus.busy, 0);
        step;
        check("mie0:busy2", bus.busy, 0);
        quiet;
        // exception beats MTI and MRET; exceptions ignore vectored mode
        bus.mstatus_mie = 1'b1;
        bus.irq_pend    = 3'b010;
        bus.irq_en      = 3'b010;
        bus.mret_req    = 1'b1;
        bus.ex_valid    = 1'b1;
        bus.ex_cause    = 4'd5;
        bus.ex_epc      = 32'h400;
        bus.ex_tval     = 32'h44;
        seq("prio", 32'h5, 32'h400, 32'h44, 32'h40);
        // MSI with base at top of memory: vectored target wraps
        bus.mtvec_base = 30'h3FFFFFFF;
        bus.irq_pend   = 3'b001;
        bus.irq_en     = 3'b001;
        bus.irq_epc    = 32'h500;
        seq("wrap", 32'h80000003, 32'h500, 32'h0, 32'h8);
        bus.mtvec_base = 30'h10;
        // pipeline never quiesces: forced advance after the drain budget
        bus.pipe_quiesced = 1'b0;
        bus.ex_valid      = 1'b1;
        bus.ex_cause      = 4'd1;
        bus.ex_epc        = 32'h600;
        bus.ex_tval       = 32'h7;
        step;
        quiet;
        for (int c = 1; c <= 15; c++) begin
            check("to:dto_early", bus.drain_timeout, 0);
            check("to:csr_we_early", bus.csr_we, 0);
            step;
        end
        check("to:dto@16", bus.drain_timeout, 1);
        check("to:busy@16", bus.busy, 1);
        step;
        check("to:dto@17", bus.drain_timeout, 0);
        check("to:csr_we@17", bus.csr_we, 1);
        check("to:mcause@17", bus.mcause_out, 32'h1);
        bus.pipe_quiesced = 1'b1;
        step;
        check("to:push@18", bus.mstatus_push, 1);
        step;
        check("to:rpc@19", bus.redirect_pc, 32'h40);
        bus.redirect_ack = 1'b1;
        step;
        bus.redirect_ack = 1'b0;
        check("to:busy_end", bus.busy, 0);
        // MRET with late ack
        bus.mepc_in  = 32'h200;
        bus.mret_req = 1'b1;
        #1 check("mret:flush@0", bus.flush, 0);
        step;
        quiet;
        check("mret:pop@1", bus.mstatus_pop, 1);
        check("mret:busy@1", bus.busy, 1);
        check("mret:rv@1", bus.redirect_valid, 0);
        step;
        bus.mepc_in = 32'h999;
        check("mret:pop@2", bus.mstatus_pop, 0);
        for (int c = 2; c <= 5; c++) begin
            check("mret:rv_held", bus.redirect_valid, 1);
            check("mret:rpc_held", bus.redirect_pc, 32'h200);
            if (c < 5) step;
        end
        bus.redirect_ack = 1'b1;
        step;
        bus.redirect_ack = 1'b0;
        check("mret:rv@6", bus.redirect_valid, 0);
        check("mret:busy@6", bus.busy, 0);
        // reset asserted during PUSH aborts at once
        bus.ex_valid = 1'b1;
        bus.ex_cause = 4'd4;
        bus.ex_epc   = 32'h700;
        bus.ex_tval  = 32'h70;
        step;
        quiet;
        step;
        step;
        check("rst:push@3", bus.mstatus_push, 1);
        #2 RST = 1'b1;
        #1 outputs_zero("rst_mid");
        step;
        step;
        RST = 1'b0;
        step;
        check("rst:idle", bus.busy, 0);
        bus.ex_valid = 1'b1;
        bus.ex_cause = 4'd3;
        bus.ex_epc   = 32'h800;
        bus.ex_tval  = 32'h88;
        seq("post", 32'h3, 32'h800, 32'h88, 32'h40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
